// File: rtl/sdram_device_responder_if.sv
// sdram_device_responder_if: SDRAM command/address pins from the controller and the device status flags.
interface sdram_device_responder_if;
    logic        SDRAM_CKE;
    logic        SDRAM_CSn;
    logic        SDRAM_RASn;
    logic        SDRAM_CASn;
    logic        SDRAM_WEn;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic [1:0]  SDRAM_DQM;
    logic        mode_set;
    logic        cmd_error;
    logic [7:0]  error_count;
    logic [15:0] refresh_count;
    modport master (
        output SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn, SDRAM_A, SDRAM_BA, SDRAM_DQM,
        input  mode_set, cmd_error, error_count, refresh_count
    );
    modport slave (
        input  SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn, SDRAM_A, SDRAM_BA, SDRAM_DQM,
        output mode_set, cmd_error, error_count, refresh_count
    );
endinterface

// File: rtl/sdram_device_responder.sv
// sdram_device_responder: reduced-depth x16 4-bank SDR SDRAM device model that decodes
// controller commands, stores write bursts and returns CAS-delayed read bursts.
module sdram_device_responder #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    sdram_device_responder_if.slave sdram,
    inout  wire  [15:0]             SDRAM_DQ
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS, C_BST} cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t              r_state, w_state_n;
    cmd_t                w_cmd;
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    logic                r_mode_set, r_cl3, r_single, r_cmd_error, r_bap;
    logic [1:0]          r_bl, r_bbank, r_dqm_d, r_oe;
    logic [7:0]          r_err_cnt;
    logic [15:0]         r_ref_cnt, r_p1_d, r_p2_d, r_dq;
    logic [COL_BITS-1:0] r_bbase;
    logic [2:0]          r_bk;
    logic [3:0]          r_blen;
    logic                r_p1_v, r_p2_v;
    logic [15:0]         r_mem [1 << AW];

    logic [1:0]          w_ba, w_bank, w_we;
    logic                w_a10, w_err, w_mrs_ok, w_new, w_new_wr, w_stop, w_cont;
    logic                w_word, w_is_wr, w_last, w_ap, w_re, w_src_v;
    logic [COL_BITS-1:0] w_base, w_mask, w_col;
    logic [2:0]          w_k;
    logic [3:0]          w_len;
    logic [AW-1:0]       w_addr;
    logic                w_unused;

    assign w_ba     = sdram.SDRAM_BA;
    assign w_a10    = sdram.SDRAM_A[10];
    assign w_mrs_ok = !sdram.SDRAM_A[2] && sdram.SDRAM_A[6:5] == 2'b01;
    assign w_unused = ^sdram.SDRAM_A[12:11];

    always_comb begin
        w_cmd = C_NOP;
        if (!sdram.SDRAM_CSn)
            case ({sdram.SDRAM_RASn, sdram.SDRAM_CASn, sdram.SDRAM_WEn})
                3'b011:  w_cmd = C_ACT;
                3'b101:  w_cmd = C_RD;
                3'b100:  w_cmd = C_WR;
                3'b010:  w_cmd = C_PRE;
                3'b001:  w_cmd = C_REF;
                3'b000:  w_cmd = C_MRS;
                3'b110:  w_cmd = C_BST;
                default: w_cmd = C_NOP;
            endcase
    end

    always_comb begin
        w_err = 1'b0;
        case (w_cmd)
            C_ACT:      w_err = r_open[w_ba];
            C_RD, C_WR: w_err = !r_mode_set || !r_open[w_ba];
            C_REF:      w_err = |r_open;
            C_MRS:      w_err = |r_open || !w_mrs_ok;
            default:    w_err = 1'b0;
        endcase
    end

    // One burst engine serves reads and writes; a legal READ/WRITE replaces any burst in flight.
    assign w_new    = (w_cmd == C_RD || w_cmd == C_WR) && !w_err;
    assign w_new_wr = w_cmd == C_WR;
    assign w_stop   = w_cmd == C_BST || (w_cmd == C_PRE && (w_a10 || w_ba == r_bbank));
    assign w_cont   = r_state != S_IDLE && !w_new && !w_stop;

    always_comb begin
        w_bank    = w_new ? w_ba : r_bbank;
        w_base    = w_new ? sdram.SDRAM_A[COL_BITS-1:0] : r_bbase;
        w_k       = w_new ? 3'd0 : r_bk;
        w_len     = !w_new ? r_blen : (w_new_wr && r_single) ? 4'd1 : 4'd1 << r_bl;
        w_ap      = w_new ? w_a10 : r_bap;
        w_is_wr   = w_new ? w_new_wr : r_state == S_WR;
        w_word    = w_new || w_cont;
        w_mask    = COL_BITS'(w_len - 4'd1);
        w_col     = (w_base & ~w_mask) | ((w_base + COL_BITS'(w_k)) & w_mask);
        w_last    = {1'b0, w_k} == w_len - 4'd1;
        w_addr    = {w_bank, r_row[w_bank], w_col};
        w_we      = (w_word && w_is_wr) ? ~sdram.SDRAM_DQM : 2'b00;
        w_re      = w_word && !w_is_wr;
        w_state_n = (!w_word || w_last) ? S_IDLE : w_is_wr ? S_WR : S_RD;
        w_src_v   = r_cl3 ? r_p2_v : r_p1_v;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_IDLE;
        else if (sdram.SDRAM_CKE) r_state <= w_state_n;

    // Storage and read data stages carry no reset: RAM contents survive a device reset.
    always_ff @(posedge clk) begin
        if (sdram.SDRAM_CKE) begin
            if (w_we[0]) r_mem[w_addr][7:0] <= SDRAM_DQ[7:0];
            if (w_we[1]) r_mem[w_addr][15:8] <= SDRAM_DQ[15:8];
            if (w_re) r_p1_d <= r_mem[w_addr];
            r_p2_d <= r_p1_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_open      <= '0;
            r_mode_set  <= 1'b0;
            r_cl3       <= 1'b0;
            r_single    <= 1'b0;
            r_bl        <= 2'd0;
            r_cmd_error <= 1'b0;
            r_err_cnt   <= '0;
            r_ref_cnt   <= '0;
            r_bbank     <= '0;
            r_bbase     <= '0;
            r_bk        <= '0;
            r_blen      <= 4'd1;
            r_bap       <= 1'b0;
            r_p1_v      <= 1'b0;
            r_p2_v      <= 1'b0;
            r_dqm_d     <= '0;
            r_oe        <= '0;
            r_dq        <= '0;
            for (int b = 0; b < 4; b++) r_row[b] <= '0;
        end else if (!sdram.SDRAM_CKE) begin
            r_cmd_error <= 1'b0;
        end else begin
            r_cmd_error <= w_err;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_cmd == C_REF && !w_err) r_ref_cnt <= r_ref_cnt + 16'd1;
            if (w_cmd == C_MRS && !w_err) begin
                r_mode_set <= 1'b1;
                r_bl       <= sdram.SDRAM_A[1:0];
                r_cl3      <= sdram.SDRAM_A[4];
                r_single   <= sdram.SDRAM_A[9];
            end
            if (w_new) begin
                r_bbank <= w_ba;
                r_bbase <= sdram.SDRAM_A[COL_BITS-1:0];
                r_bk    <= 3'd1;
                r_blen  <= w_len;
                r_bap   <= w_a10;
            end else if (w_cont) begin
                r_bk <= r_bk + 3'd1;
            end
            for (int b = 0; b < 4; b++) begin
                if (w_cmd == C_ACT && !w_err && w_ba == 2'(b)) begin
                    r_open[b] <= 1'b1;
                    r_row[b]  <= sdram.SDRAM_A[ROW_BITS-1:0];
                end
                if (w_cmd == C_PRE && (w_a10 || w_ba == 2'(b))) r_open[b] <= 1'b0;
                if (w_word && w_last && w_ap && w_bank == 2'(b)) r_open[b] <= 1'b0;
            end
            // DQM is delayed one edge so it masks the word sampled two edges later.
            r_p1_v  <= w_re;
            r_p2_v  <= r_p1_v;
            r_dqm_d <= sdram.SDRAM_DQM;
            r_oe    <= {2{w_src_v}} & ~r_dqm_d;
            r_dq    <= r_cl3 ? r_p2_d : r_p1_d;
        end
    end

    assign SDRAM_DQ[7:0]       = r_oe[0] ? r_dq[7:0] : 8'hzz;
    assign SDRAM_DQ[15:8]      = r_oe[1] ? r_dq[15:8] : 8'hzz;
    assign sdram.mode_set      = r_mode_set;
    assign sdram.cmd_error     = r_cmd_error;
    assign sdram.error_count   = r_err_cnt;
    assign sdram.refresh_count = r_ref_cnt;
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed checks of mode set, bursts, wrap, masking, errors, CKE stall and reset.
module tb_sdram_device_responder;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
    localparam logic [2:0] PRE = 3'b010, REF = 3'b001, MRS = 3'b000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    int          n_chk = 0;
    int          n_bad = 0;
    tri1  [15:0] dq;

    sdram_device_responder_if sif();
    assign dq = tb_oe ? tb_dq : 16'hzzzz;

    sdram_device_responder dut (
        .clk     (clk),
        .reset   (reset),
        .sdram   (sif),
        .SDRAM_DQ(dq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
        {sif.SDRAM_RASn, sif.SDRAM_CASn, sif.SDRAM_WEn} = c;
        sif.SDRAM_BA = ba;
        sif.SDRAM_A  = a;
        @(negedge clk);
        {sif.SDRAM_RASn, sif.SDRAM_CASn, sif.SDRAM_WEn} = NOP;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        sif.SDRAM_CKE = 1'b1;
        sif.SDRAM_CSn = 1'b0;
        {sif.SDRAM_RASn, sif.SDRAM_CASn, sif.SDRAM_WEn} = NOP;
        sif.SDRAM_A   = '0;
        sif.SDRAM_BA  = '0;
        sif.SDRAM_DQM = '0;
        tick();
        tick();
        check("rst_mode_set", 16'(sif.mode_set), 16'h0);
        check("rst_cmd_error", 16'(sif.cmd_error), 16'h0);
        check("rst_error_count", 16'(sif.error_count), 16'h0);
        check("rst_refresh_count", sif.refresh_count, 16'h0);
        check("rst_dq_hiz", dq, 16'hFFFF);
        reset = 1'b0;
        tick();

        issue(MRS, 2'd0, 13'h021);
        check("mrs_mode_set", 16'(sif.mode_set), 16'h1);
        check("mrs_no_error", 16'(sif.cmd_error), 16'h0);
        issue(MRS, 2'd0, 13'h027);
        check("mrs_bad_error", 16'(sif.cmd_error), 16'h1);
        tick();
        check("err_pulse_end", 16'(sif.cmd_error), 16'h0);

        issue(ACT, 2'd0, 13'h001);
        check("act_ok", 16'(sif.cmd_error), 16'h0);
        tb_oe = 1'b1;
        tb_dq = 16'h0025;
        issue(WR, 2'd0, 13'd12);
        tb_dq = 16'h0000;
        tick();
        tb_oe = 1'b0;
        issue(RD, 2'd0, 13'd12);
        check("bl2_pre_data", dq, 16'hFFFF);
        tick();
        check("bl2_word0", dq, 16'h0025);
        tick();
        check("bl2_word1", dq, 16'h0000);
        tick();
        check("bl2_hiz_after", dq, 16'hFFFF);

        issue(PRE, 2'd0, 13'h000);
        issue(MRS, 2'd0, 13'h022);
        issue(ACT, 2'd0, 13'h001);
        tb_oe = 1'b1;
        tb_dq = 16'h000A;
        issue(WR, 2'd0, 13'd6);
        tb_dq = 16'h000B;
        tick();
        tb_dq = 16'h000C;
        tick();
        tb_dq = 16'h000D;
        tick();
        tb_oe = 1'b0;
        issue(RD, 2'd0, 13'd4);
        tick();
        check("bl4_wrap_w0", dq, 16'h000C);
        tick();
        check("bl4_wrap_w1", dq, 16'h000D);
        tick();
        check("bl4_wrap_w2", dq, 16'h000A);
        tick();
        check("bl4_wrap_w3", dq, 16'h000B);
        tick();
        check("bl4_hiz_after", dq, 16'hFFFF);

        issue(PRE, 2'd0, 13'h000);
        issue(MRS, 2'd0, 13'h020);
        issue(ACT, 2'd0, 13'h001);
        tb_oe = 1'b1;
        tb_dq = 16'hFFFF;
        issue(WR, 2'd0, 13'd20);
        tb_dq = 16'h1234;
        sif.SDRAM_DQM = 2'b01;
        issue(WR, 2'd0, 13'd20);
        sif.SDRAM_DQM = 2'b00;
        tb_dq = 16'h5A3C;
        issue(WR, 2'd0, 13'd21);
        tb_oe = 1'b0;
        issue(RD, 2'd0, 13'd20);
        tick();
        check("wr_mask_lo", dq, 16'h12FF);
        sif.SDRAM_DQM = 2'b10;
        issue(RD, 2'd0, 13'd21);
        sif.SDRAM_DQM = 2'b00;
        tick();
        check("rd_mask_hi", dq, 16'hFF3C);
        tick();
        check("rd_mask_hiz_after", dq, 16'hFFFF);

        do_reset();
        check("rst2_mode_set", 16'(sif.mode_set), 16'h0);
        issue(MRS, 2'd0, 13'h021);
        issue(RD, 2'd1, 13'h000);
        check("rd_closed_error", 16'(sif.cmd_error), 16'h1);
        tick();
        check("rd_closed_nodrive0", dq, 16'hFFFF);
        tick();
        check("rd_closed_nodrive1", dq, 16'hFFFF);
        issue(ACT, 2'd2, 13'h000);
        check("act2_ok", 16'(sif.cmd_error), 16'h0);
        issue(ACT, 2'd2, 13'h000);
        check("act_open_error", 16'(sif.cmd_error), 16'h1);
        issue(REF, 2'd0, 13'h000);
        check("ref_open_error", 16'(sif.cmd_error), 16'h1);
        check("error_count3", 16'(sif.error_count), 16'd3);
        check("ref_rejected", sif.refresh_count, 16'd0);
        issue(PRE, 2'd0, 13'h400);
        issue(REF, 2'd0, 13'h000);
        check("ref_ok_count", sif.refresh_count, 16'd1);
        check("ref_ok_no_error", 16'(sif.cmd_error), 16'h0);

        issue(MRS, 2'd0, 13'h031);
        issue(ACT, 2'd0, 13'h001);
        issue(RD, 2'd0, 13'd4);
        sif.SDRAM_CKE = 1'b0;
        tick();
        sif.SDRAM_CKE = 1'b1;
        tick();
        check("cl3_cke_not_yet", dq, 16'hFFFF);
        tick();
        check("cl3_cke_w0", dq, 16'h000C);
        tick();
        check("cl3_cke_w1", dq, 16'h000D);
        tick();
        check("cl3_cke_hiz", dq, 16'hFFFF);

        issue(RD, 2'd0, 13'd4);
        tick();
        check("cl3_not_yet", dq, 16'hFFFF);
        tick();
        check("cl3_w0", dq, 16'h000C);
        reset = 1'b1;
        #1;
        check("rst_mid_hiz", dq, 16'hFFFF);
        check("rst_mid_mode_set", 16'(sif.mode_set), 16'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_device_responder.md
# sdram_device_responder

Synthesizable, reduced-depth model of an SDR SDRAM device (x16, 4 banks) that answers the command/data pin interface driven by the SDRAM controller. It decodes SDRAM commands, tracks per-bank open rows, stores data in internal RAM, and returns read bursts with programmable CAS latency. It replaces the vendor behavioural model in FPGA-resident loopback builds and bench regressions, and flags illegal command sequences.

## Interface
- ROW_BITS, default 2: row address bits stored; higher SDRAM_A bits are ignored, so rows alias.
- COL_BITS, default 9: column bits, taken from SDRAM_A[COL_BITS-1:0].
- Storage is 4 × 2^ROW_BITS × 2^COL_BITS words of 16 bits.
- clk  in  1  device clock; wired to the same net as SDRAM_CLK.
- reset  in  1  asynchronous, active-high.
- SDRAM_CKE  in  1  clock enable.
- SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn  in  1 each  command pins.
- SDRAM_A  in  13  row, column and mode address; A10 selects auto-precharge / all banks.
- SDRAM_BA  in  2  bank select.
- SDRAM_DQM  in  2  byte masks; bit0 covers DQ[7:0], bit1 covers DQ[15:8].
- SDRAM_DQ  inout  16  data; high-Z unless driving read data.
- mode_set  out  1  high once a valid MRS has been accepted.
- cmd_error  out  1  one-cycle pulse on an illegal command.
- error_count  out  8  saturating count of cmd_error pulses.
- refresh_count  out  16  wrapping count of accepted AREF commands.

## Operation
- Command pins and DQ are sampled on the rising edge of clk.
- CKE low at an edge: the edge is ignored entirely. Command decode, burst counters and the read pipeline all freeze, and DQ holds its state.
- CSn high is treated as NOP.
- Command decode on (RASn, CASn, WEn):
  - 111: NOP.
  - 011: ACT.
  - 101: READ.
  - 100: WRITE.
  - 010: PRE.
  - 001: AREF.
  - 000: MRS.
  - 110: BST, which ends the current burst.
- Each bank keeps an open flag and an open-row register.
- ACT to a closed bank opens it with row = A[ROW_BITS-1:0]. ACT to an open bank is an error and is ignored.
- PRE closes bank BA; with A10=1 it closes all banks. PRE to an idle bank is legal and does nothing.
- READ/WRITE to a closed bank is an error and is ignored. READ/WRITE before mode_set is also an error.
- READ/WRITE with A10=1 closes the bank after the last burst word.
- AREF or MRS while any bank is open is an error and is ignored.
- MRS fields:
  - A[2:0] burst length: 000=1, 001=2, 010=4, 011=8.
  - A[6:4] CAS latency: 010=2, 011=3.
  - A9=1 selects single-word writes.
  - Any other BL or CL encoding is an error and leaves the mode unchanged.
  - A3 is ignored; bursts are always sequential.
- Burst addressing: word k uses column {base[COL_BITS-1:b], (base[b-1:0]+k) mod BL}, with b=log2(BL). The burst wraps inside its BL-aligned block.
- A new READ/WRITE truncates the active burst immediately; the new burst starts at once. PRE or BST to the bursting bank stops further words.
- Write masking: a word with DQM bit high leaves that byte unchanged in RAM.

## Timing
- Reset values: mode_set=0, cmd_error=0, error_count=0, refresh_count=0, all banks closed, BL=1, CL=2, DQ high-Z.
- Reset acts asynchronously and clears the pipeline mid-burst. RAM contents are not cleared.
- WRITE at edge n: word k is captured from DQ at edge n+k, for k=0..BL-1. With A9=1 only word 0 is captured.
- READ at edge n: word k is driven from just after edge n+CL-1+k until edge n+CL+k, so it is sampled at edge n+CL+k. DQ returns to high-Z after the last word.
- Read masking: DQM sampled at edge m tri-states the byte that would be sampled at edge m+2.
- Read words already in the pipeline when a truncating command arrives are still driven. The pipeline is CL entries deep.
- Auto-precharge closes the bank at the edge of the last burst word. An ACT to that bank at the following edge is legal.
- cmd_error is high for the single cycle after the offending edge. error_count increments on that same edge.

## Test plan
- Reset then MRS with A=0x021 (BL=2, CL=2) -> mode_set=1, cmd_error=0. Then MRS with A=0x027 -> cmd_error pulse, mode stays BL=2/CL=2.
- ACT BA=0 row 1, then WRITE col 12 with DQ=0x0025 then 0x0000, then READ col 12 -> DQ sampled 0x0025 at n+2 and 0x0000 at n+3, high-Z at n+4.
- BL=4, WRITE col 6 with data A,B,C,D, then READ col 4 -> returns C,D,A,B (wrap within block 4..7).
- WRITE 0x1234 with DQM=01 over 0xFFFF -> reads 0x12FF. READ with DQM=10 at edge n -> upper byte high-Z at n+2.
- READ to a closed bank, ACT to an open bank, and AREF with a bank open -> three cmd_error pulses, error_count=3, no DQ drive. PRE A10=1, then AREF -> refresh_count=1.
- CL=3 READ with CKE low for one cycle mid-burst, and separately reset asserted mid-burst -> data shifted one cycle later; reset forces immediate high-Z and mode_set=0.
